// File: rtl/dsram_arbiter.sv
// Shares the single-ported data SRAM between instruction fetch and load/store,
// with a starvation guard for fetch and 1-cycle read response routing.
//
// resp_own | meaning
// ---------+----------------------------------------------
// NONE     | no read issued last cycle, no response due
// IF       | SRAM data this cycle belongs to instruction fetch
// LS       | SRAM data this cycle belongs to load/store
module dsram_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [3:0]  ls_sel,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_gnt,
  output logic        ls_rvalid,
  output logic [31:0] ls_rdata,
  output logic        sram_en,
  output logic [3:0]  sram_we,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata,
  output logic        stall_req_if,
  output logic        stall_req_ls
);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_IF   = 2'd1;
  localparam logic [1:0] OWN_LS   = 2'd2;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] r_starve_cnt;
  logic [1:0]       r_resp_own;
  logic [CNT_W-1:0] w_starve_nxt;
  logic [1:0]       w_own_nxt;
  logic             w_if_gnt;
  logic             w_ls_gnt;
  logic             w_if_forced;

  // Grants are gated by rst_n so nothing reaches the SRAM while in reset.
  always_comb begin
    w_if_forced = (r_starve_cnt == LIMIT);
    w_if_gnt    = rst_n & if_req & (~ls_req | w_if_forced);
    w_ls_gnt    = rst_n & ls_req & ~w_if_gnt;
  end

  assign if_gnt       = w_if_gnt;
  assign ls_gnt       = w_ls_gnt;
  assign stall_req_if = if_req & ~w_if_gnt;
  assign stall_req_ls = ls_req & ~w_ls_gnt;

  always_comb begin
    sram_en    = w_if_gnt | w_ls_gnt;
    sram_addr  = '0;
    sram_we    = 4'b0000;
    sram_wdata = '0;
    if (w_if_gnt) begin
      sram_addr = if_addr;
    end else if (w_ls_gnt) begin
      sram_addr  = ls_addr;
      sram_wdata = ls_wdata;
      if (ls_we) sram_we = ls_sel;
    end
  end

  // Counts consecutive fetch denials; saturates so fetch stays forced until served.
  always_comb begin
    w_starve_nxt = r_starve_cnt;
    if (w_if_gnt || !if_req) begin
      w_starve_nxt = '0;
    end else if (w_ls_gnt && (r_starve_cnt != LIMIT)) begin
      w_starve_nxt = r_starve_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    w_own_nxt = OWN_NONE;
    if (w_if_gnt)                w_own_nxt = OWN_IF;
    else if (w_ls_gnt && !ls_we) w_own_nxt = OWN_LS;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
      r_resp_own   <= OWN_NONE;
    end else begin
      r_starve_cnt <= w_starve_nxt;
      r_resp_own   <= w_own_nxt;
    end
  end

  assign if_rvalid = (r_resp_own == OWN_IF);
  assign ls_rvalid = (r_resp_own == OWN_LS);
  assign if_rdata  = if_rvalid ? sram_rdata : '0;
  assign ls_rdata  = ls_rvalid ? sram_rdata : '0;

endmodule

// File: tb/tb_dsram_arbiter.sv
// Directed and randomized checks of dsram_arbiter against a denial-count /
// pending-response reference model.
module tb_dsram_arbiter;

  localparam int LIMIT = 4;

  logic        clk, rst_n;
  logic        if_req, ls_req, ls_we;
  logic [31:0] if_addr, ls_addr, ls_wdata, sram_rdata;
  logic [3:0]  ls_sel;
  logic        if_gnt, if_rvalid, ls_gnt, ls_rvalid, sram_en;
  logic        stall_req_if, stall_req_ls;
  logic [31:0] if_rdata, ls_rdata, sram_addr, sram_wdata;
  logic [3:0]  sram_we;

  int  n_tests = 0;
  int  n_fail  = 0;
  int  m_deny  = 0;      // consecutive fetch denials while LS was served
  byte m_owner = "N";    // who the SRAM data belongs to this cycle

  dsram_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_sel(ls_sel), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .stall_req_if(stall_req_if), .stall_req_ls(stall_req_ls)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check combinational outputs and responses, then advance the model.
  task automatic step(input logic [31:0] rd);
    bit eg_if, eg_ls, ev_if, ev_ls;
    sram_rdata = rd;
    @(negedge clk);
    eg_if = 0; eg_ls = 0;
    if (rst_n) begin
      if (if_req && ls_req) begin
        if (m_deny == LIMIT) eg_if = 1; else eg_ls = 1;
      end else if (if_req) eg_if = 1;
      else if (ls_req) eg_ls = 1;
    end
    ev_if = rst_n && (m_owner == "I");
    ev_ls = rst_n && (m_owner == "L");
    chk("if_gnt", 32'(if_gnt), 32'(eg_if));
    chk("ls_gnt", 32'(ls_gnt), 32'(eg_ls));
    chk("sram_en", 32'(sram_en), 32'(eg_if | eg_ls));
    chk("sram_we", 32'(sram_we), (eg_ls && ls_we) ? 32'(ls_sel) : 32'd0);
    chk("sram_addr", sram_addr, eg_if ? if_addr : (eg_ls ? ls_addr : 32'd0));
    chk("sram_wdata", sram_wdata, eg_ls ? ls_wdata : 32'd0);
    chk("stall_if", 32'(stall_req_if), 32'(if_req && !eg_if));
    chk("stall_ls", 32'(stall_req_ls), 32'(ls_req && !eg_ls));
    chk("if_rvalid", 32'(if_rvalid), 32'(ev_if));
    chk("ls_rvalid", 32'(ls_rvalid), 32'(ev_ls));
    chk("if_rdata", if_rdata, ev_if ? rd : 32'd0);
    chk("ls_rdata", ls_rdata, ev_ls ? rd : 32'd0);
    @(posedge clk);
    if (!rst_n) begin
      m_deny = 0; m_owner = "N";
    end else begin
      m_owner = eg_if ? "I" : ((eg_ls && !ls_we) ? "L" : "N");
      if (!if_req || eg_if) m_deny = 0;
      else if (eg_ls && m_deny < LIMIT) m_deny++;
    end
    #1;
  endtask

  task automatic set_if(input bit req, input logic [31:0] a);
    if_req = req; if_addr = a;
  endtask

  task automatic set_ls(input bit req, input bit we, input logic [3:0] sel,
                        input logic [31:0] a, input logic [31:0] d);
    ls_req = req; ls_we = we; ls_sel = sel; ls_addr = a; ls_wdata = d;
  endtask

  initial begin
    rst_n = 1'b0;
    set_if(1, 32'h40);
    set_ls(1, 1, 4'hF, 32'h80, 32'h55AA55AA);
    sram_rdata = '0;
    step(32'h11111111);   // requests during reset: no grant, no SRAM drive
    step(32'h22222222);
    rst_n = 1'b1;

    // IF only read, data returns next cycle
    set_ls(0, 0, 4'h0, 32'h0, 32'h0);
    set_if(1, 32'h100);
    step($urandom);
    set_if(0, 32'h0);
    step(32'hDEADBEEF);

    // LS partial write, no response follows
    set_ls(1, 1, 4'b0011, 32'h200, 32'h1234ABCD);
    step($urandom);
    set_ls(0, 0, 4'h0, 32'h0, 32'h0);
    step($urandom);

    // Simultaneous reads: LS first, then IF once LS drops
    set_if(1, 32'h300);
    set_ls(1, 0, 4'hF, 32'h304, 32'h0);
    step($urandom);
    set_ls(0, 0, 4'h0, 32'h0, 32'h0);
    step($urandom);
    set_if(0, 32'h0);
    step($urandom);

    // Both held: LS x4, forced IF, LS again
    set_if(1, 32'h400);
    set_ls(1, 0, 4'hF, 32'h404, 32'h0);
    for (int i = 0; i < 7; i++) step($urandom);
    set_if(0, 32'h0);
    set_ls(0, 0, 4'h0, 32'h0, 32'h0);
    step($urandom);

    // Alternating single-requester reads every cycle
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) begin set_if(1, 32'h500 + i); set_ls(0, 0, 4'h0, 32'h0, 32'h0); end
      else begin set_if(0, 32'h0); set_ls(1, 0, 4'hF, 32'h600 + i, 32'h0); end
      step($urandom);
    end
    set_if(0, 32'h0);
    set_ls(0, 0, 4'h0, 32'h0, 32'h0);
    step($urandom);

    // Reset right after an IF read grant discards the response
    set_if(1, 32'h700);
    step($urandom);
    rst_n = 1'b0;
    step($urandom);
    rst_n = 1'b1;
    step($urandom);
    set_if(0, 32'h0);
    step($urandom);

    // Randomized traffic biased toward contention
    for (int i = 0; i < 400; i++) begin
      set_if($urandom_range(0, 3) != 0, $urandom);
      set_ls($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, 4'($urandom), $urandom, $urandom);
      step($urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
